// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command master.
package apb_cmd_pkg;

  localparam int unsigned APB_ADDR_W = 12;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  // Register offsets of the timer slave, for use by benches and sequencers.
  localparam logic [11:0] TIM_TCR   = 12'h000;
  localparam logic [11:0] TIM_TDR0  = 12'h004;
  localparam logic [11:0] TIM_TDR1  = 12'h008;
  localparam logic [11:0] TIM_TCMP0 = 12'h00C;
  localparam logic [11:0] TIM_TCMP1 = 12'h010;
  localparam logic [11:0] TIM_TIER  = 12'h014;
  localparam logic [11:0] TIM_TISR  = 12'h018;
  localparam logic [11:0] TIM_THCSR = 12'h01C;

endpackage

// File: rtl/apb_cmd_tmo_cnt.sv
// Counts ACCESS wait cycles and flags the cycle on which the transfer must be
// abandoned. TIMEOUT_CYC = 0 removes the counter entirely (wait forever).
module apb_cmd_tmo_cnt #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic pready,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      logic [CNT_W-1:0] cnt;

      // Wait-cycle counter: cleared while entering ACCESS, bumps per stalled cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en && !pready) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      // A pready arriving on the final cycle masks the abort.
      assign expire = en && !pready && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 initiator: one register command in, one APB transfer out, one response back.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                apb_psel,
  output logic                apb_penable,
  output logic                apb_pwrite,
  output logic [ADDR_W-1:0]   apb_paddr,
  output logic [DATA_W-1:0]   apb_pwdata,
  output logic [DATA_W/8-1:0] apb_pstrb,
  input  logic [DATA_W-1:0]   apb_prdata,
  input  logic                apb_pready,
  input  logic                apb_pslverr
);

  state_e              state, state_n;
  logic                cmd_ready_n, rsp_valid_n, rsp_err_n, rsp_timeout_n;
  logic [DATA_W-1:0]   rsp_rdata_n;
  logic                psel_n, penable_n, pwrite_n;
  logic [ADDR_W-1:0]   paddr_n;
  logic [DATA_W-1:0]   pwdata_n;
  logic [DATA_W/8-1:0] pstrb_n;
  logic                expire;

  apb_cmd_tmo_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_tmo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clr    (state == SETUP),
    .en     (state == ACCESS),
    .pready (apb_pready),
    .expire (expire)
  );

  // Next state and next value of every registered output. The APB output
  // registers double as the command latch, loaded on the accept edge.
  always_comb begin
    state_n       = state;
    cmd_ready_n   = cmd_ready;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_err_n     = rsp_err;
    rsp_timeout_n = rsp_timeout;
    psel_n        = apb_psel;
    penable_n     = apb_penable;
    pwrite_n      = apb_pwrite;
    paddr_n       = apb_paddr;
    pwdata_n      = apb_pwdata;
    pstrb_n       = apb_pstrb;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n     = SETUP;
          cmd_ready_n = 1'b0;
          psel_n      = 1'b1;
          pwrite_n    = cmd_write;
          paddr_n     = cmd_addr;
          pwdata_n    = cmd_wdata;
          pstrb_n     = cmd_write ? cmd_strb : '0;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
      end
      ACCESS: begin
        if (apb_pready || expire) begin
          state_n       = RESP;
          rsp_valid_n   = 1'b1;
          rsp_timeout_n = !apb_pready;
          rsp_err_n     = apb_pready ? apb_pslverr : 1'b1;
          rsp_rdata_n   = (apb_pready && !apb_pwrite) ? apb_prdata : '0;
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          pwrite_n      = 1'b0;
          paddr_n       = '0;
          pwdata_n      = '0;
          pstrb_n       = '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n       = IDLE;
          cmd_ready_n   = 1'b1;
          rsp_valid_n   = 1'b0;
          rsp_rdata_n   = '0;
          rsp_err_n     = 1'b0;
          rsp_timeout_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_pwrite  <= 1'b0;
      apb_paddr   <= '0;
      apb_pwdata  <= '0;
      apb_pstrb   <= '0;
    end else begin
      state       <= state_n;
      cmd_ready   <= cmd_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
      apb_psel    <= psel_n;
      apb_penable <= penable_n;
      apb_pwrite  <= pwrite_n;
      apb_paddr   <= paddr_n;
      apb_pwdata  <= pwdata_n;
      apb_pstrb   <= pstrb_n;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master against a small timer-like APB slave model.
module tb_apb_cmd_master;
  import apb_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [11:0] apb_paddr;
  logic [31:0] apb_pwdata, apb_prdata;
  logic [3:0]  apb_pstrb;
  logic        apb_pready = 1'b0, apb_pslverr;

  int errors = 0;
  int checks = 0;
  int both_high = 0;

  apb_cmd_master #(
    .ADDR_W      (12),
    .DATA_W      (32),
    .TIMEOUT_CYC (8),
    .CNT_W       (16)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_paddr   (apb_paddr),
    .apb_pwdata  (apb_pwdata),
    .apb_pstrb   (apb_pstrb),
    .apb_prdata  (apb_prdata),
    .apb_pready  (apb_pready),
    .apb_pslverr (apb_pslverr)
  );

  always #5 clk = ~clk;

  // Slave model: eight registers, programmable wait states, error injection.
  logic [31:0] mem [8];
  int unsigned wait_cfg = 0;
  int unsigned wcnt = 0;
  bit          err_mode = 1'b0;

  assign apb_prdata  = err_mode ? 32'hDEAD_BEEF : mem[apb_paddr[4:2]];
  // pslverr also toggles during wait states; only the pready cycle counts.
  assign apb_pslverr = err_mode | (apb_penable & ~apb_pready);

  always @(negedge clk) begin
    if (apb_psel && apb_penable) begin
      apb_pready = (wcnt == wait_cfg);
      wcnt = wcnt + 1;
    end else begin
      apb_pready = 1'b0;
      wcnt = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h0000_0100;
      mem[3] <= 32'hFFFF_FFFF;
    end else if (apb_psel && apb_penable && apb_pready && apb_pwrite && !err_mode) begin
      for (int b = 0; b < 4; b++)
        if (apb_pstrb[b]) mem[apb_paddr[4:2]][8*b +: 8] <= apb_pwdata[8*b +: 8];
    end
  end

  always @(negedge clk) if (rsp_valid && cmd_ready) both_high++;

  typedef struct {
    bit          rst;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          err_inj;
    int          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_to;
    int          exp_lat;
    int          exp_pen;
  } vec_t;

  function automatic vec_t mk(bit rst, bit wr, logic [11:0] addr, logic [31:0] wdata,
                              logic [3:0] strb, int waits, bit err_inj, int hold,
                              logic [31:0] er, bit ee, bit et, int el, int ep);
    vec_t v;
    v.rst = rst; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.waits = waits; v.err_inj = err_inj; v.hold = hold;
    v.exp_rdata = er; v.exp_err = ee; v.exp_to = et; v.exp_lat = el; v.exp_pen = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; err_mode = 1'b0; wait_cfg = 0;
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 64'h0);
    chk("rst_bus", {apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_cmd(input vec_t v);
    logic [31:0] r_d;
    logic        r_e, r_t;
    logic [3:0]  exp_strb;
    int          lat, pen;
    bit          bus_bad, hold_bad;
    if (v.rst) do_reset();
    exp_strb = v.wr ? v.strb : 4'h0;
    @(negedge clk);
    wait_cfg = v.waits; err_mode = v.err_inj;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_strb = v.strb;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'h1);
    @(posedge clk); #1;
    // Scramble the request inputs: the DUT must hold its latched copy.
    cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_strb = ~v.strb;
    lat = 1; pen = 0; bus_bad = 1'b0;
    chk("setup_ctl", {apb_psel, apb_penable, apb_pwrite, cmd_ready}, {60'h0, 1'b1, 1'b0, v.wr, 1'b0});
    chk("setup_addr", 64'(apb_paddr), 64'(v.addr));
    chk("setup_wdata", 64'(apb_pwdata), 64'(v.wdata));
    chk("setup_strb", 64'(apb_pstrb), 64'(exp_strb));
    while (!rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (apb_penable) begin
        pen++;
        if (!apb_psel || apb_pwrite !== v.wr || apb_paddr !== v.addr ||
            apb_pwdata !== v.wdata || apb_pstrb !== exp_strb) bus_bad = 1'b1;
      end
      if (cmd_ready) bus_bad = 1'b1;
    end
    chk("latency", 64'(lat), 64'(v.exp_lat));
    chk("penable_cycles", 64'(pen), 64'(v.exp_pen));
    chk("bus_stable", 64'(bus_bad), 64'h0);
    chk("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
    chk("rsp_flags", {rsp_err, rsp_timeout}, {62'h0, v.exp_err, v.exp_to});
    chk("bus_idle_resp", {apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata, apb_pstrb}, 64'h0);
    r_d = rsp_rdata; r_e = rsp_err; r_t = rsp_timeout; hold_bad = 1'b0;
    repeat (v.hold) begin
      @(posedge clk); #1;
      if (!rsp_valid || cmd_ready || rsp_rdata !== r_d || rsp_err !== r_e || rsp_timeout !== r_t)
        hold_bad = 1'b1;
    end
    if (v.hold > 0) chk("rsp_hold", 64'(hold_bad), 64'h0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; err_mode = 1'b0;
    chk("rsp_done", {rsp_valid, cmd_ready}, 64'h1);
  endtask

  vec_t vecs [15];

  initial begin
    int first_acc, second_acc, cyc;
    bit noresp_bad;

    vecs[0]  = mk(1, 0, TIM_TCR,   32'h0,         4'hF, 1,   0, 0, 32'h0000_0100, 0, 0, 4,  2);
    vecs[1]  = mk(0, 1, TIM_TCMP0, 32'h1234_5678, 4'hF, 0,   0, 0, 32'h0,         0, 0, 3,  1);
    vecs[2]  = mk(0, 0, TIM_TCMP0, 32'h0BAD_0BAD, 4'hF, 0,   0, 0, 32'h1234_5678, 0, 0, 3,  1);
    vecs[3]  = mk(0, 1, TIM_TDR0,  32'hCAFE_F00D, 4'h5, 2,   0, 0, 32'h0,         0, 0, 5,  3);
    vecs[4]  = mk(0, 0, TIM_TDR0,  32'h0,         4'hF, 0,   0, 0, 32'h00FE_000D, 0, 0, 3,  1);
    vecs[5]  = mk(0, 0, TIM_THCSR, 32'h0,         4'hF, 3,   0, 0, 32'h0,         0, 0, 6,  4);
    vecs[6]  = mk(0, 1, TIM_TDR1,  32'h1111_1111, 4'hF, 0,   1, 0, 32'h0,         1, 0, 3,  1);
    vecs[7]  = mk(0, 0, TIM_TDR1,  32'h0,         4'hF, 0,   0, 0, 32'h0,         0, 0, 3,  1);
    vecs[8]  = mk(0, 0, TIM_TCR,   32'h0,         4'hF, 7,   0, 0, 32'h0000_0100, 0, 0, 10, 8);
    vecs[9]  = mk(0, 0, TIM_TCR,   32'h0,         4'hF, 255, 0, 0, 32'h0,         1, 1, 10, 8);
    vecs[10] = mk(0, 1, TIM_TIER,  32'h5A5A_5A5A, 4'hF, 255, 0, 0, 32'h0,         1, 1, 10, 8);
    vecs[11] = mk(1, 1, TIM_TCMP0, 32'hAABB_CCDD, 4'h2, 0,   0, 0, 32'h0,         0, 0, 3,  1);
    vecs[12] = mk(0, 0, TIM_TCMP0, 32'h0,         4'hF, 0,   0, 0, 32'hFFFF_CCFF, 0, 0, 3,  1);
    vecs[13] = mk(0, 0, TIM_TCR,   32'h0,         4'hF, 0,   1, 5, 32'hDEAD_BEEF, 1, 0, 3,  1);
    vecs[14] = mk(0, 0, TIM_TIER,  32'h0,         4'hF, 0,   0, 0, 32'h0,         0, 0, 3,  1);

    #1;
    for (int i = 0; i < 15; i++) run_cmd(vecs[i]);

    // Back-to-back reads with request and response always ready.
    @(negedge clk);
    wait_cfg = 0; err_mode = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = TIM_TCR; cmd_strb = 4'hF;
    first_acc = -1; second_acc = -1;
    for (int c = 0; c < 12; c++) begin
      if (cmd_valid && cmd_ready) begin
        if (first_acc < 0) first_acc = c;
        else if (second_acc < 0) second_acc = c;
      end
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    chk("b2b_period", 64'(second_acc - first_acc), 64'h4);

    // Asynchronous reset in the middle of a stalled ACCESS phase.
    @(negedge clk);
    wait_cfg = 255; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = TIM_TCR;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_in_access", {apb_psel, apb_penable}, 64'h3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus", {apb_psel, apb_penable, rsp_valid}, 64'h0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'h1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wait_cfg = 0;
    noresp_bad = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid || !cmd_ready || apb_psel) noresp_bad = 1'b1;
    end
    chk("mid_no_response", 64'(noresp_bad), 64'h0);
    run_cmd(mk(0, 0, TIM_TCR, 32'h0, 4'hF, 0, 0, 0, 32'h0000_0100, 0, 0, 3, 1));

    chk("valid_ready_excl", 64'(both_high), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
